// File: rtl/sort_mem_responder_pkg.sv
// Shared response codes and FSM state encodings for the sort engine memory responder.
package sort_mem_responder_pkg;

  localparam logic RESP_OKAY = 1'b1;
  localparam logic RESP_ERR  = 1'b0;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

endpackage

// File: rtl/mem_regfile.sv
// DEPTH x DATA_WDTH register file: one write port, one registered-sample read port.
module mem_regfile #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [ADDR_WDTH-1:0] waddr_i,
  input  logic [DATA_WDTH-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_WDTH-1:0] raddr_i,
  output logic [DATA_WDTH-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WDTH-1:0] mem_q [DEPTH];
  logic [DATA_WDTH-1:0] rdata_q;
  logic [IDX_W-1:0]     widx;
  logic [IDX_W-1:0]     ridx;

  // Callers only assert we_i/re_i for in-range addresses, so the low bits suffice.
  assign widx    = waddr_i[IDX_W-1:0];
  assign ridx    = raddr_i[IDX_W-1:0];
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[ridx];
  end

endmodule

// File: rtl/sort_mem_responder.sv
// Slave memory for the sort engine: independent read (AR/R) and write (AW/W/B) FSMs
// in front of a register file, with an address range check producing the response.
module sort_mem_responder
  import sort_mem_responder_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int DEPTH     = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ar_valid,
  input  logic [ADDR_WDTH-1:0] ar_addr,
  output logic                 ar_ready,
  output logic                 r_valid,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 r_ready,
  input  logic                 aw_valid,
  input  logic [ADDR_WDTH-1:0] aw_addr,
  output logic                 aw_ready,
  input  logic                 w_valid,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 w_ready,
  output logic                 b_valid,
  output logic [RESP_WDTH-1:0] b_resp,
  input  logic                 b_ready
);

  localparam logic [RESP_WDTH-1:0] OKAY = RESP_WDTH'(RESP_OKAY);
  localparam logic [RESP_WDTH-1:0] ERR  = RESP_WDTH'(RESP_ERR);

  function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  rstate_e                r_state_q, r_state_d;
  logic [ADDR_WDTH-1:0]   r_addr_q, r_addr_d;
  logic [3:0]             r_cnt_q, r_cnt_d;
  logic [RESP_WDTH-1:0]   r_resp_q;
  logic                   r_load;
  logic [ADDR_WDTH-1:0]   r_load_addr;

  wstate_e                w_state_q, w_state_d;
  logic [ADDR_WDTH-1:0]   w_addr_q, w_addr_d;
  logic [RESP_WDTH-1:0]   b_resp_q, b_resp_d;
  logic                   mem_we;
  logic [DATA_WDTH-1:0]   mem_rdata;

  // With zero latency the sample happens on the AR handshake itself, so use the live address.
  assign r_load_addr = (r_state_q == R_IDLE) ? ar_addr : r_addr_q;

  assign ar_ready = (r_state_q == R_IDLE);
  assign r_valid  = (r_state_q == R_DATA);
  assign r_resp   = r_resp_q;
  assign r_data   = (r_resp_q == OKAY) ? mem_rdata : '0;
  assign aw_ready = (w_state_q == W_IDLE);
  assign w_ready  = (w_state_q == W_DATA);
  assign b_valid  = (w_state_q == W_RESP);
  assign b_resp   = b_resp_q;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_load    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_valid) begin
          r_addr_d = ar_addr;
          if (READ_LAT == 0) begin
            r_load    = 1'b1;
            r_state_d = R_DATA;
          end else begin
            r_cnt_d   = 4'(READ_LAT);
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q == 4'd1) begin
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA:  if (r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      r_resp_q  <= ERR;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      if (r_load) r_resp_q <= in_range(r_load_addr) ? OKAY : ERR;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    b_resp_d  = b_resp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_valid) begin
          w_addr_d  = aw_addr;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_valid) begin
          mem_we    = in_range(w_addr_q);
          b_resp_d  = in_range(w_addr_q) ? OKAY : ERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP:  if (b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      b_resp_q  <= ERR;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      b_resp_q  <= b_resp_d;
    end
  end

  mem_regfile #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (mem_we),
    .waddr_i(w_addr_q),
    .wdata_i(w_data),
    .re_i   (r_load && in_range(r_load_addr)),
    .raddr_i(r_load_addr),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_sort_mem_responder.sv
// Directed bench: three responder instances (DEPTH 8/LAT 1, DEPTH 16/LAT 0, DEPTH 16/LAT 3).
module tb_sort_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        ar_valid [3];
  logic [3:0]  ar_addr  [3];
  logic        ar_ready [3];
  logic        r_valid  [3];
  logic [31:0] r_data   [3];
  logic        r_resp   [3];
  logic        r_ready  [3];
  logic        aw_valid [3];
  logic [3:0]  aw_addr  [3];
  logic        aw_ready [3];
  logic        w_valid  [3];
  logic [31:0] w_data   [3];
  logic        w_ready  [3];
  logic        b_valid  [3];
  logic        b_resp   [3];
  logic        b_ready  [3];

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sort_mem_responder #(
      .ADDR_WDTH(4),
      .DATA_WDTH(32),
      .RESP_WDTH(1),
      .DEPTH    ((g == 0) ? 8 : 16),
      .READ_LAT ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ar_valid(ar_valid[g]),
      .ar_addr (ar_addr[g]),
      .ar_ready(ar_ready[g]),
      .r_valid (r_valid[g]),
      .r_data  (r_data[g]),
      .r_resp  (r_resp[g]),
      .r_ready (r_ready[g]),
      .aw_valid(aw_valid[g]),
      .aw_addr (aw_addr[g]),
      .aw_ready(aw_ready[g]),
      .w_valid (w_valid[g]),
      .w_data  (w_data[g]),
      .w_ready (w_ready[g]),
      .b_valid (b_valid[g]),
      .b_resp  (b_resp[g]),
      .b_ready (b_ready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic write_txn(input int k, input logic [3:0] a, input logic [31:0] d,
                           input int hold, input logic [31:0] exp_resp,
                           output logic [31:0] resp, output int lat);
    int n;
    @(negedge clk);
    aw_valid[k] = 1'b1; aw_addr[k] = a; w_valid[k] = 1'b1; w_data[k] = d; b_ready[k] = 1'b0;
    n = 0;
    while (!aw_ready[k] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    aw_valid[k] = 1'b0;
    n = 1;
    while (!b_valid[k] && n < 20) begin
      if (w_ready[k]) begin @(negedge clk); w_valid[k] = 1'b0; end
      else @(negedge clk);
      n++;
    end
    lat  = n;
    resp = 32'(b_resp[k]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("b_hold_valid", 32'(b_valid[k]), 32'd1);
      chk("b_hold_resp", 32'(b_resp[k]), exp_resp);
      chk("b_hold_aw_ready", 32'(aw_ready[k]), 32'd0);
    end
    b_ready[k] = 1'b1;
    @(negedge clk);
    b_ready[k] = 1'b0;
    w_valid[k] = 1'b0;
  endtask

  task automatic read_txn(input int k, input logic [3:0] a, input int hold,
                          input logic [31:0] exp_data, input logic [31:0] exp_resp,
                          output logic [31:0] data, output logic [31:0] resp, output int lat);
    int n;
    @(negedge clk);
    ar_valid[k] = 1'b1; ar_addr[k] = a; r_ready[k] = 1'b0;
    n = 0;
    while (!ar_ready[k] && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    ar_valid[k] = 1'b0;
    n = 1;
    while (!r_valid[k] && n < 30) begin @(negedge clk); n++; end
    lat  = n;
    data = r_data[k];
    resp = 32'(r_resp[k]);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(r_valid[k]), 32'd1);
      chk("r_hold_data", r_data[k], exp_data);
      chk("r_hold_resp", 32'(r_resp[k]), exp_resp);
      chk("r_hold_ar_ready", 32'(ar_ready[k]), 32'd0);
    end
    r_ready[k] = 1'b1;
    @(negedge clk);
    r_ready[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic        is_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [31:0] exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] rd, rs, rd2, rs2;
    int          lt, lt2;

    vecs[0]  = '{0, 1'b1, 4'd3,  32'h5,        32'h0,  32'd1, 2};
    vecs[1]  = '{0, 1'b0, 4'd3,  32'h0,        32'h5,  32'd1, 2};
    vecs[2]  = '{0, 1'b1, 4'd1,  32'h7,        32'h0,  32'd1, 2};
    vecs[3]  = '{0, 1'b0, 4'd15, 32'h0,        32'h0,  32'd0, 2};
    vecs[4]  = '{0, 1'b1, 4'd9,  32'hFFFF_FFFF, 32'h0, 32'd0, 2};
    vecs[5]  = '{0, 1'b0, 4'd1,  32'h0,        32'h7,  32'd1, 2};
    vecs[6]  = '{0, 1'b0, 4'd9,  32'h0,        32'h0,  32'd0, 2};
    vecs[7]  = '{0, 1'b1, 4'd2,  32'hA,        32'h0,  32'd1, 2};
    vecs[8]  = '{1, 1'b1, 4'd7,  32'h77,       32'h0,  32'd1, 2};
    vecs[9]  = '{1, 1'b0, 4'd7,  32'h0,        32'h77, 32'd1, 1};
    vecs[10] = '{2, 1'b0, 4'd7,  32'h0,        32'h0,  32'd1, 4};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ar_valid[k] = 1'b0; ar_addr[k] = '0; r_ready[k] = 1'b0;
      aw_valid[k] = 1'b0; aw_addr[k] = '0; w_valid[k] = 1'b0; w_data[k] = '0; b_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      chk("rst_ar_ready", 32'(ar_ready[k]), 32'd1);
      chk("rst_aw_ready", 32'(aw_ready[k]), 32'd1);
      chk("rst_w_ready", 32'(w_ready[k]), 32'd0);
      chk("rst_r_valid", 32'(r_valid[k]), 32'd0);
      chk("rst_b_valid", 32'(b_valid[k]), 32'd0);
      chk("rst_r_data", r_data[k], 32'd0);
      chk("rst_r_resp", 32'(r_resp[k]), 32'd0);
      chk("rst_b_resp", 32'(b_resp[k]), 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        write_txn(vecs[i].k, vecs[i].addr, vecs[i].wdata, 0, vecs[i].exp_resp, rs, lt);
        chk($sformatf("vec%0d_b_resp", i), rs, vecs[i].exp_resp);
        chk($sformatf("vec%0d_b_lat", i), lt, vecs[i].exp_lat);
      end else begin
        read_txn(vecs[i].k, vecs[i].addr, 0, vecs[i].exp_data, vecs[i].exp_resp, rd, rs, lt);
        chk($sformatf("vec%0d_r_data", i), rd, vecs[i].exp_data);
        chk($sformatf("vec%0d_r_resp", i), rs, vecs[i].exp_resp);
        chk($sformatf("vec%0d_r_lat", i), lt, vecs[i].exp_lat);
      end
    end

    read_txn(0, 4'd3, 5, 32'h5, 32'd1, rd, rs, lt);
    chk("hold_r_data", rd, 32'h5);
    write_txn(0, 4'd5, 32'h55, 5, 32'd1, rs, lt);
    chk("hold_b_resp", rs, 32'd1);
    read_txn(0, 4'd5, 0, 32'h55, 32'd1, rd, rs, lt);
    chk("hold_wr_readback", rd, 32'h55);

    fork
      read_txn(0, 4'd2, 0, 32'hA, 32'd1, rd, rs, lt);
      write_txn(0, 4'd2, 32'hB, 0, 32'd1, rs2, lt2);
    join
    chk("coll_old_data", rd, 32'hA);
    chk("coll_b_resp", rs2, 32'd1);
    read_txn(0, 4'd2, 0, 32'hB, 32'd1, rd, rs, lt);
    chk("coll_new_data", rd, 32'hB);

    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        write_txn(k, 4'(i), 32'h100 + 32'(i), 0, 32'd1, rs, lt);
        chk($sformatf("sweep%0d_b_resp_%0d", k, i), rs, 32'd1);
      end
      for (int i = 0; i < 16; i++) begin
        read_txn(k, 4'(i), 0, 32'h100 + 32'(i), 32'd1, rd, rs, lt);
        chk($sformatf("sweep%0d_data_%0d", k, i), rd, 32'h100 + 32'(i));
        chk($sformatf("sweep%0d_resp_%0d", k, i), rs, 32'd1);
        chk($sformatf("sweep%0d_lat_%0d", k, i), lt, (k == 1) ? 1 : 4);
      end
    end

    @(negedge clk);
    aw_valid[0] = 1'b1; aw_addr[0] = 4'd4; w_valid[0] = 1'b0;
    ar_valid[2] = 1'b1; ar_addr[2] = 4'd5;
    @(negedge clk);
    aw_valid[0] = 1'b0; ar_valid[2] = 1'b0;
    chk("pre_rst_w_ready", 32'(w_ready[0]), 32'd1);
    chk("pre_rst_ar_ready", 32'(ar_ready[2]), 32'd0);
    rst_n = 1'b0;
    w_valid[0] = 1'b1; w_data[0] = 32'hDEAD;
    #1;
    chk("arst_w_ready", 32'(w_ready[0]), 32'd0);
    chk("arst_aw_ready", 32'(aw_ready[0]), 32'd1);
    chk("arst_b_valid", 32'(b_valid[0]), 32'd0);
    chk("arst_ar_ready", 32'(ar_ready[2]), 32'd1);
    chk("arst_r_valid", 32'(r_valid[2]), 32'd0);
    chk("arst_r_data", r_data[2], 32'd0);
    @(negedge clk);
    w_valid[0] = 1'b0;
    rst_n = 1'b1;
    read_txn(0, 4'd4, 0, 32'h0, 32'd1, rd, rs, lt);
    chk("arst_target_word", rd, 32'h0);
    chk("arst_target_resp", rs, 32'd1);
    read_txn(0, 4'd3, 0, 32'h0, 32'd1, rd, rs, lt);
    chk("arst_mem_cleared", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
